grant_finish_unit: RTL and testbench

GRANT_FINISH_UNIT -- requirements
Module: grant_finish_unit

---
 rtl/grant_finish_unit_pkg.sv | 34 +++
 rtl/grant_finish_unit_if.sv | 61 ++++++
 rtl/grant_finish_unit_finish_fifo.sv | 68 ++++++
 rtl/grant_finish_unit.sv | 64 ++++++
 tb/tb_grant_finish_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/grant_finish_unit_pkg.sv
// Shared constants and types for the grant finish unit.
// Grant type encodings, beat geometry and the finish record layout live here
// so the top level and the finish queue agree on them.
package grant_pkg;

    localparam logic [3:0] G_TYPE_DATA_BLOCK = 4'd5;
    localparam logic [3:0] G_TYPE_GNT_SHARED = 4'd0;
    localparam int         BEATS             = 8;
    localparam int         BEAT_W            = 3;

    // Grant header (everything except the data payload).
    typedef struct packed {
        logic [2:0] addr_beat;
        logic [1:0] client_xact_id;
        logic       manager_xact_id;
        logic       is_builtin_type;
        logic [3:0] g_type;
        logic       client_id;
    } grant_hdr_t;

    // Record stored in the finish queue.
    typedef struct packed {
        logic manager_xact_id;
        logic client_id;
    } finish_t;

    // A grant carries a data block (8 beats) for built-in data-block grants
    // and for non-built-in shared grants; everything else is a single beat.
    function automatic logic is_multibeat(input logic builtin, input logic [3:0] g_type);
        return (builtin && (g_type == G_TYPE_DATA_BLOCK)) ||
               (!builtin && (g_type == G_TYPE_GNT_SHARED));
    endfunction

endpackage

// File: rtl/grant_finish_unit_if.sv
// Grant/finish bundle: input grant stream, output grant stream and the
// finish stream. The unit itself uses the slave modport; whatever drives
// grants in and consumes grants/finishes uses the master modport.
// Handshake: a transfer happens on a rising clk edge where valid && ready;
// valid must not depend on ready from the same side, bits are stable while
// valid is high and not yet accepted.
interface grant_finish_unit_if #(
    parameter int DATA_W = 64
);
    logic              io_in_ready;
    logic              io_in_valid;
    logic [2:0]        io_in_bits_addr_beat;
    logic [1:0]        io_in_bits_client_xact_id;
    logic              io_in_bits_manager_xact_id;
    logic              io_in_bits_is_builtin_type;
    logic [3:0]        io_in_bits_g_type;
    logic [DATA_W-1:0] io_in_bits_data;
    logic              io_in_bits_client_id;

    logic              io_out_ready;
    logic              io_out_valid;
    logic [2:0]        io_out_bits_addr_beat;
    logic [1:0]        io_out_bits_client_xact_id;
    logic              io_out_bits_manager_xact_id;
    logic              io_out_bits_is_builtin_type;
    logic [3:0]        io_out_bits_g_type;
    logic [DATA_W-1:0] io_out_bits_data;
    logic              io_out_bits_client_id;

    logic              io_fin_ready;
    logic              io_fin_valid;
    logic              io_fin_bits_manager_xact_id;
    logic              io_fin_bits_client_id;

    modport slave (
        output io_in_ready,
        input  io_in_valid, io_in_bits_addr_beat, io_in_bits_client_xact_id,
               io_in_bits_manager_xact_id, io_in_bits_is_builtin_type,
               io_in_bits_g_type, io_in_bits_data, io_in_bits_client_id,
        input  io_out_ready,
        output io_out_valid, io_out_bits_addr_beat, io_out_bits_client_xact_id,
               io_out_bits_manager_xact_id, io_out_bits_is_builtin_type,
               io_out_bits_g_type, io_out_bits_data, io_out_bits_client_id,
        input  io_fin_ready,
        output io_fin_valid, io_fin_bits_manager_xact_id, io_fin_bits_client_id
    );

    modport master (
        input  io_in_ready,
        output io_in_valid, io_in_bits_addr_beat, io_in_bits_client_xact_id,
               io_in_bits_manager_xact_id, io_in_bits_is_builtin_type,
               io_in_bits_g_type, io_in_bits_data, io_in_bits_client_id,
        output io_out_ready,
        input  io_out_valid, io_out_bits_addr_beat, io_out_bits_client_xact_id,
               io_out_bits_manager_xact_id, io_out_bits_is_builtin_type,
               io_out_bits_g_type, io_out_bits_data, io_out_bits_client_id,
        output io_fin_ready,
        input  io_fin_valid, io_fin_bits_manager_xact_id, io_fin_bits_client_id
    );

endinterface

// File: rtl/grant_finish_unit_finish_fifo.sv
// Finish queue: small power-of-two FIFO with registered occupancy.
// Macro FINISH_FLOW_EN: when defined, an enqueue into an empty queue is
// presented on the dequeue side in the same cycle and skips storage if it
// is taken immediately. When undefined the queue is fully registered.
// The caller must not enqueue while full is high.
module finish_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic             enq_valid,
    input  logic [WIDTH-1:0] enq_data,
    output logic             full,
    input  logic             deq_ready,
    output logic             deq_valid,
    output logic [WIDTH-1:0] deq_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, bypass, do_enq, do_deq;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Output selection and bypass decision.
    always_comb begin
`ifdef FINISH_FLOW_EN
        bypass    = empty && enq_valid && deq_ready;
        deq_valid = !empty || enq_valid;
        deq_data  = empty ? enq_data : mem[rd_ptr];
`else
        bypass    = 1'b0;
        deq_valid = !empty;
        deq_data  = mem[rd_ptr];
`endif
    end

    assign do_enq = enq_valid && !full && !bypass;
    assign do_deq = deq_valid && deq_ready && !bypass;

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/grant_finish_unit.sv
// Grant finish unit: forwards grants from the arbiter to the client with no
// added latency, counts beats of multibeat grants, and queues one finish
// record per non-built-in grant message on its last beat. Grants whose last
// beat needs a finish are held off while the finish queue is full.
// Macro FINISH_FLOW_EN selects same-cycle finish presentation (see finish_fifo).
module grant_finish_unit
    import grant_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int FQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    grant_finish_unit_if.slave bus,
    output logic [BEAT_W-1:0] beat_count  // current beat index of a multibeat grant
);
    logic    multibeat, last, needs_finish, gate, fire, fq_full, fq_enq;
    finish_t fq_in, fq_out;

    assign multibeat    = is_multibeat(bus.io_in_bits_is_builtin_type, bus.io_in_bits_g_type);
    assign last         = !multibeat || (beat_count == BEAT_W'(BEATS - 1));
    assign needs_finish = !bus.io_in_bits_is_builtin_type;
    assign gate         = !(last && needs_finish) || !fq_full;

    assign bus.io_in_ready  = bus.io_out_ready && gate;
    assign bus.io_out_valid = bus.io_in_valid && gate;
    assign fire             = bus.io_in_valid && bus.io_in_ready;

    assign bus.io_out_bits_addr_beat       = bus.io_in_bits_addr_beat;
    assign bus.io_out_bits_client_xact_id  = bus.io_in_bits_client_xact_id;
    assign bus.io_out_bits_manager_xact_id = bus.io_in_bits_manager_xact_id;
    assign bus.io_out_bits_is_builtin_type = bus.io_in_bits_is_builtin_type;
    assign bus.io_out_bits_g_type          = bus.io_in_bits_g_type;
    assign bus.io_out_bits_data            = bus.io_in_bits_data[DATA_W-1:0];
    assign bus.io_out_bits_client_id       = bus.io_in_bits_client_id;

    // Beat counter: advances on each accepted multibeat beat, wraps 7 -> 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) beat_count <= '0;
        else if (fire && multibeat) beat_count <= beat_count + 1'b1;
    end

    assign fq_enq = fire && last && needs_finish;
    assign fq_in  = '{manager_xact_id: bus.io_in_bits_manager_xact_id,
                      client_id:       bus.io_in_bits_client_id};

    finish_fifo #(
        .WIDTH($bits(finish_t)),
        .DEPTH(FQ_DEPTH)
    ) u_finish_fifo (
        .clk      (clk),
        .reset    (reset),
        .enq_valid(fq_enq),
        .enq_data (fq_in),
        .full     (fq_full),
        .deq_ready(bus.io_fin_ready),
        .deq_valid(bus.io_fin_valid),
        .deq_data (fq_out)
    );

    assign bus.io_fin_bits_manager_xact_id = fq_out.manager_xact_id;
    assign bus.io_fin_bits_client_id       = fq_out.client_id;

endmodule

// File: tb/tb_grant_finish_unit.sv
// Directed bench for grant_finish_unit (DATA_W=64, FQ_DEPTH=2).
// Finish records are predicted when a grant is driven and compared in
// order when the unit hands them out.
module tb_grant_finish_unit;
    localparam logic FLOW_EXP =
`ifdef FINISH_FLOW_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [2:0] beat_count;

    grant_finish_unit_if #(.DATA_W(64)) bus ();

    grant_finish_unit #(.DATA_W(64), .FQ_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .beat_count(beat_count)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [1:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         fin_seen = 0;
    logic [2:0] mdl_cnt  = 3'd0;
    logic       cur_mb, cur_last;
    logic [75:0] cur_bits;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Finish monitor: every finish handed out must match the oldest prediction.
    always @(negedge clk) begin
        if (reset && bus.io_fin_valid && bus.io_fin_ready) begin
            fin_seen++;
            if (exp_q.size() == 0) begin
                check("fin_unexpected", 1, 0);
            end else begin
                check("fin_bits", {bus.io_fin_bits_manager_xact_id, bus.io_fin_bits_client_id},
                      exp_q.pop_front());
            end
        end
    end

    // Driver: present a grant beat and record what the model predicts for it.
    task automatic start_beat(input logic [3:0] gt, input logic bi, input logic mx, input logic cid);
        logic [63:0] d;
        logic [1:0]  cx;
        logic [2:0]  ab;
        d        = {$urandom, $urandom};
        cx       = 2'($urandom_range(0, 3));
        cur_mb   = (bi && gt == 4'd5) || (!bi && gt == 4'd0);
        cur_last = !cur_mb || (mdl_cnt == 3'd7);
        ab       = cur_mb ? mdl_cnt : 3'd0;
        bus.io_in_bits_addr_beat       = ab;
        bus.io_in_bits_client_xact_id  = cx;
        bus.io_in_bits_manager_xact_id = mx;
        bus.io_in_bits_is_builtin_type = bi;
        bus.io_in_bits_g_type          = gt;
        bus.io_in_bits_data            = d;
        bus.io_in_bits_client_id       = cid;
        bus.io_in_valid                = 1'b1;
        cur_bits = {ab, cx, mx, bi, gt, cid, d};
        if (cur_last && !bi) exp_q.push_back({mx, cid});
    endtask

    task automatic finish_beat(output int stalls);
        stalls = 0;
        @(negedge clk);
        while (!bus.io_in_ready && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        if (!bus.io_in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            check("out_valid", bus.io_out_valid, 1);
            check("out_bits", {bus.io_out_bits_addr_beat, bus.io_out_bits_client_xact_id,
                               bus.io_out_bits_manager_xact_id, bus.io_out_bits_is_builtin_type,
                               bus.io_out_bits_g_type, bus.io_out_bits_client_id,
                               bus.io_out_bits_data}, cur_bits);
            if (cur_mb) mdl_cnt = mdl_cnt + 3'd1;
        end
        @(posedge clk);
        #1;
        bus.io_in_valid = 1'b0;
        check("beat_count", beat_count, mdl_cnt);
    endtask

    task automatic send_beat(input logic [3:0] gt, input logic bi, input logic mx, input logic cid);
        int st;
        start_beat(gt, bi, mx, cid);
        finish_beat(st);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        int st;
        int seen0;
        reset            = 1'b0;
        bus.io_in_valid  = 1'b0;
        bus.io_in_bits_addr_beat       = '0;
        bus.io_in_bits_client_xact_id  = '0;
        bus.io_in_bits_manager_xact_id = 1'b0;
        bus.io_in_bits_is_builtin_type = 1'b0;
        bus.io_in_bits_g_type          = '0;
        bus.io_in_bits_data            = '0;
        bus.io_in_bits_client_id       = 1'b0;
        bus.io_out_ready = 1'b1;
        bus.io_fin_ready = 1'b0;
        idle(3);
        @(negedge clk);
        reset = 1'b1;
        idle(1);

        // Reset state
        @(negedge clk);
        check("rst_fin_valid", bus.io_fin_valid, 0);
        check("rst_beat_count", beat_count, 0);
        check("rst_in_ready", bus.io_in_ready, 1);
        check("rst_out_valid", bus.io_out_valid, 0);
        idle(1);

        // Single-beat built-in grant: zero latency, no finish, counter stays 0
        send_beat(4'd3, 1'b1, 1'b0, 1'b1);
        idle(2);
        check("single_builtin_no_fin", bus.io_fin_valid, 0);
        check("single_builtin_cnt", beat_count, 0);

        // Single non-built-in grant into an empty queue: finish timing
        bus.io_fin_ready = 1'b0;
        start_beat(4'd3, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("empty_accept", bus.io_in_ready, 1);
        check("empty_fin_same_cycle", bus.io_fin_valid, FLOW_EXP);
        @(posedge clk);
        #1;
        bus.io_in_valid = 1'b0;
        @(negedge clk);
        check("empty_fin_next_cycle", bus.io_fin_valid, 1);
        @(posedge clk);
        #1;
        bus.io_fin_ready = 1'b1;
        idle(2);
        check("empty_drained", exp_q.size(), 0);
        check("empty_fin_low", bus.io_fin_valid, 0);

        // Non-built-in 8-beat grant: one finish {1,0} after beat 7
        seen0 = fin_seen;
        for (int i = 0; i < 8; i++) begin
            send_beat(4'd0, 1'b0, 1'b1, 1'b0);
            if (i < 7) check("multi_no_early_fin", bus.io_fin_valid, 0);
        end
        idle(3);
        check("multi_one_fin", fin_seen - seen0, 1);
        check("multi_cnt_wrap", beat_count, 0);

        // Output stalled: nothing advances or enqueues
        bus.io_out_ready = 1'b0;
        start_beat(4'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("oready0_in_ready", bus.io_in_ready, 0);
            check("oready0_out_valid", bus.io_out_valid, 1);
        end
        @(posedge clk);
        #1;
        bus.io_in_valid  = 1'b0;
        bus.io_out_ready = 1'b1;
        check("oready0_cnt", beat_count, 0);
        check("oready0_no_fin", bus.io_fin_valid, 0);

        // Queue fills with fin_ready low; third grant stalls until a drain
        bus.io_fin_ready = 1'b0;
        send_beat(4'd3, 1'b0, 1'b0, 1'b1);
        send_beat(4'd3, 1'b0, 1'b1, 1'b0);
        start_beat(4'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", bus.io_in_ready, 0);
            check("full_out_valid", bus.io_out_valid, 0);
        end
        @(posedge clk);
        #1;
        bus.io_fin_ready = 1'b1;
        // Drain and pending last beat coincide: accept lands one cycle later
        finish_beat(st);
        check("full_stall_cycles", st, 1);
        idle(4);
        check("full_drained", exp_q.size(), 0);

        // Reset in the middle of an 8-beat grant with a finish queued
        bus.io_fin_ready = 1'b0;
        send_beat(4'd7, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(4'd0, 1'b0, 1'b0, 1'b0);
        check("mid_cnt_before_rst", beat_count, 4);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mdl_cnt = 3'd0;
        idle(2);
        @(negedge clk);
        check("mid_rst_cnt", beat_count, 0);
        check("mid_rst_fin_valid", bus.io_fin_valid, 0);
        reset = 1'b1;
        idle(1);
        bus.io_fin_ready = 1'b1;
        seen0 = fin_seen;
        for (int i = 0; i < 8; i++) send_beat(4'd0, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("post_rst_one_fin", fin_seen - seen0, 1);
        check("post_rst_drained", exp_q.size(), 0);
        check("post_rst_cnt", beat_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
